// File: rtl/alu_seq.sv
// Sequential signed ALU: add/sub/shl/sar in one cycle, shift-add multiply over W cycles.
// Results are sign-extended to 2*W bits and held until the consumer accepts them.
module alu_seq #(
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     op1,
  input  logic [W-1:0]     op2,
  input  logic [2:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   result,
  output logic             ovf,
  output logic             err
);
  localparam int RW = 2 * W;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  state_t state, state_n;

  logic [RW-1:0] result_n, mcand, mcand_n, acc, acc_n, sum;
  logic [W-1:0]  mplier, mplier_n, mag1, mag2;
  logic [CW-1:0] cnt, cnt_n;
  logic          sign, sign_n, ovf_n, err_n;
  logic [RW-1:0] ext1, ext2, shl_v;
  logic [31:0]   amt;

  assign ext1  = {{W{op1[W-1]}}, op1};
  assign ext2  = {{W{op2[W-1]}}, op2};
  assign amt   = 32'(op2);
  assign shl_v = ext1 << amt;
  // Magnitude of -2^(W-1) is 2^(W-1), which still fits as an unsigned W-bit value.
  assign mag1  = op1[W-1] ? -op1 : op1;
  assign mag2  = op2[W-1] ? -op2 : op2;
  assign sum   = acc + (mplier[0] ? mcand : '0);

  always_comb begin
    state_n   = state;
    result_n  = result;
    ovf_n     = ovf;
    err_n     = err;
    mcand_n   = mcand;
    mplier_n  = mplier;
    acc_n     = acc;
    cnt_n     = cnt;
    sign_n    = sign;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          ovf_n   = 1'b0;
          err_n   = 1'b0;
          state_n = DONE;
          case (opcode)
            3'b000: result_n = ext1 + ext2;
            3'b001: result_n = ext1 - ext2;
            3'b010: begin
              if (op2[W-1]) begin
                result_n = '0;
                err_n    = 1'b1;
              end else if (amt >= 32'(RW)) begin
                result_n = '0;
                ovf_n    = |op1;
              end else begin
                result_n = shl_v;
                ovf_n    = ($signed(shl_v) >>> amt) != $signed(ext1);
              end
            end
            3'b011: begin
              if (op2[W-1]) begin
                result_n = '0;
                err_n    = 1'b1;
              end else if (amt >= 32'(RW)) begin
                result_n = {RW{op1[W-1]}};
              end else begin
                result_n = $signed(ext1) >>> amt;
              end
            end
            3'b100: begin
              mcand_n  = {{W{1'b0}}, mag1};
              mplier_n = mag2;
              acc_n    = '0;
              cnt_n    = CW'(W);
              sign_n   = op1[W-1] ^ op2[W-1];
              state_n  = MUL;
            end
            default: begin
              result_n = '0;
              err_n    = 1'b1;
            end
          endcase
        end
      end
      MUL: begin
        acc_n    = sum;
        mcand_n  = mcand << 1;
        mplier_n = mplier >> 1;
        cnt_n    = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          result_n = sign ? -sum : sum;
          state_n  = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      result <= '0;
      ovf    <= 1'b0;
      err    <= 1'b0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      sign   <= 1'b0;
    end else begin
      state  <= state_n;
      result <= result_n;
      ovf    <= ovf_n;
      err    <= err_n;
      mcand  <= mcand_n;
      mplier <= mplier_n;
      acc    <= acc_n;
      cnt    <= cnt_n;
      sign   <= sign_n;
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (W=8): directed cases from the arithmetic rules plus random
// transactions checked against an integer-arithmetic reference model.
module tb_alu_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  op1 = '0, op2 = '0;
  logic [2:0]  opcode = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] result;
  logic        ovf, err;

  int vectors = 0;
  int miscompares = 0;

  alu_seq #(.W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op1(op1), .op2(op2), .opcode(opcode), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .ovf(ovf), .err(err)
  );

  always #5 clk = ~clk;

  // Reference: exact integer arithmetic on the signed operand values.
  function automatic void model(input logic [2:0] opc, input logic [7:0] a, input logic [7:0] b,
                                output logic [15:0] r, output logic o, output logic e);
    longint x, y, p, d;
    x = longint'($signed(a));
    y = longint'($signed(b));
    r = '0; o = 1'b0; e = 1'b0;
    case (opc)
      3'd0: r = 16'(x + y);
      3'd1: r = 16'(x - y);
      3'd2: begin
        if (y < 0) e = 1'b1;
        else if (y >= 16) o = (x != 0);
        else begin
          p = x * (longint'(1) << y);
          r = 16'(p);
          o = (p > 32767) || (p < -32768);
        end
      end
      3'd3: begin
        if (y < 0) e = 1'b1;
        else if (y >= 16) r = (x < 0) ? 16'hFFFF : 16'h0000;
        else begin
          d = longint'(1) << y;
          p = x / d;
          if (x < 0 && p * d != x) p = p - 1;
          r = 16'(p);
        end
      end
      3'd4: r = 16'(x * y);
      default: e = 1'b1;
    endcase
  endfunction

  // Applies one transaction from IDLE, returns what the DUT presented in DONE and
  // the number of edges from the accept edge to out_valid; then releases it.
  task automatic run_txn(input logic [2:0] opc, input logic [7:0] a, input logic [7:0] b,
                         output logic [15:0] r, output logic o, output logic e,
                         output int lat, output int busy);
    @(negedge clk);
    opcode = opc; op1 = a; op2 = b; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; op1 = 8'($urandom); op2 = 8'($urandom);
    lat = 1; busy = 0;
    while (!out_valid && lat < 50) begin
      if (in_ready) busy++;
      @(posedge clk); #1;
      lat++;
    end
    r = result; o = ovf; e = err;
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || result !== 16'h0 || ovf !== 1'b0 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs got ov=%b r=%h ovf=%b err=%b, want 0 0 0 0", out_valid, result, ovf, err);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release got in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_add_sub;
    logic [2:0]  opc[2] = '{3'd0, 3'd1};
    logic [7:0]  a[2]   = '{8'd127, 8'h80};
    logic [7:0]  b[2]   = '{8'd127, 8'd127};
    logic [15:0] want[2] = '{16'h00FE, 16'hFF01};
    logic [15:0] r; logic o, e; int lat, busy;
    for (int i = 0; i < 2; i++) begin
      run_txn(opc[i], a[i], b[i], r, o, e, lat, busy);
      vectors++;
      if (r !== want[i] || o !== 1'b0 || e !== 1'b0 || lat != 1) begin
        miscompares++;
        $display("FAIL add_sub[%0d] got r=%h ovf=%b err=%b lat=%0d, want r=%h ovf=0 err=0 lat=1",
                 i, r, o, e, lat, want[i]);
      end
    end
  endtask

  task automatic test_shifts;
    logic [2:0]  opc[5]  = '{3'd2, 3'd2, 3'd3, 3'd3, 3'd2};
    logic [7:0]  a[5]    = '{8'h40, 8'd3, 8'h80, 8'hFF, 8'd5};
    logic [7:0]  b[5]    = '{8'd9, 8'd2, 8'd3, 8'd20, 8'hFF};
    logic [15:0] want[5] = '{16'h8000, 16'd12, 16'hFFF0, 16'hFFFF, 16'h0000};
    logic        wo[5]   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        we[5]   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [15:0] r; logic o, e; int lat, busy;
    for (int i = 0; i < 5; i++) begin
      run_txn(opc[i], a[i], b[i], r, o, e, lat, busy);
      vectors++;
      if (r !== want[i] || o !== wo[i] || e !== we[i] || lat != 1) begin
        miscompares++;
        $display("FAIL shift[%0d] got r=%h ovf=%b err=%b lat=%0d, want r=%h ovf=%b err=%b lat=1",
                 i, r, o, e, lat, want[i], wo[i], we[i]);
      end
    end
  endtask

  task automatic test_mul;
    logic [7:0]  a[3]    = '{8'h80, 8'd127, 8'd0};
    logic [7:0]  b[3]    = '{8'h80, 8'h80, 8'hFB};
    logic [15:0] want[3] = '{16'd16384, 16'hC080, 16'h0000};
    logic [15:0] r; logic o, e; int lat, busy;
    for (int i = 0; i < 3; i++) begin
      run_txn(3'd4, a[i], b[i], r, o, e, lat, busy);
      vectors++;
      if (r !== want[i] || o !== 1'b0 || e !== 1'b0 || lat != 9 || busy != 0) begin
        miscompares++;
        $display("FAIL mul[%0d] got r=%h ovf=%b err=%b lat=%0d in_ready_hi=%0d, want r=%h 0 0 lat=9 in_ready_hi=0",
                 i, r, o, e, lat, busy, want[i]);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [15:0] r; logic o, e; int lat, busy;
    @(negedge clk);
    opcode = 3'd0; op1 = 8'd10; op2 = 8'd20; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1; in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; opcode = 3'($urandom); op1 = 8'($urandom); op2 = 8'($urandom);
      @(posedge clk); #1;
      vectors++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 16'd30 || ovf !== 1'b0 || err !== 1'b0) begin
        miscompares++;
        $display("FAIL hold[%0d] got ov=%b ir=%b r=%h ovf=%b err=%b, want 1 0 001e 0 0",
                 i, out_valid, in_ready, result, ovf, err);
      end
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL release got out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    end
    run_txn(3'd1, 8'd5, 8'd9, r, o, e, lat, busy);
    vectors++;
    if (r !== 16'hFFFC || lat != 1) begin
      miscompares++;
      $display("FAIL after_release got r=%h lat=%0d, want fffc lat=1", r, lat);
    end
  endtask

  task automatic test_illegal;
    logic [15:0] r; logic o, e; int lat, busy;
    run_txn(3'b111, 8'd33, 8'd44, r, o, e, lat, busy);
    vectors++;
    if (r !== 16'h0 || e !== 1'b1 || o !== 1'b0) begin
      miscompares++;
      $display("FAIL illegal got r=%h ovf=%b err=%b, want 0000 0 1", r, o, e);
    end
    run_txn(3'd0, 8'd1, 8'd1, r, o, e, lat, busy);
    vectors++;
    if (r !== 16'd2 || e !== 1'b0) begin
      miscompares++;
      $display("FAIL err_clear got r=%h err=%b, want 0002 0", r, e);
    end
  endtask

  task automatic test_reset_mid_mul;
    logic [15:0] r; logic o, e; int lat, busy;
    @(negedge clk);
    opcode = 3'd4; op1 = 8'hFD; op2 = 8'd7; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || result !== 16'h0 || ovf !== 1'b0 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_mul got ov=%b r=%h ovf=%b err=%b, want 0 0 0 0", out_valid, result, ovf, err);
    end
    @(negedge clk); rst_n = 1'b1;
    run_txn(3'd0, 8'd2, 8'd3, r, o, e, lat, busy);
    vectors++;
    if (r !== 16'd5 || o !== 1'b0 || e !== 1'b0 || lat != 1) begin
      miscompares++;
      $display("FAIL post_reset_add got r=%h ovf=%b err=%b lat=%0d, want 0005 0 0 lat=1", r, o, e, lat);
    end
  endtask

  task automatic test_random;
    logic [15:0] r, wr; logic o, e, wo, we; int lat, busy;
    logic [2:0] opc; logic [7:0] a, b;
    for (int i = 0; i < 60; i++) begin
      opc = 3'($urandom);
      a = 8'($urandom);
      b = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 20)) : 8'($urandom);
      model(opc, a, b, wr, wo, we);
      run_txn(opc, a, b, r, o, e, lat, busy);
      vectors++;
      if (r !== wr || o !== wo || e !== we || lat != ((opc == 3'd4) ? 9 : 1)) begin
        miscompares++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h got r=%h ovf=%b err=%b lat=%0d, want r=%h ovf=%b err=%b",
                 i, opc, a, b, r, o, e, lat, wr, wo, we);
      end
    end
  endtask

  task automatic test_back_to_back;
    int n, t;
    logic [2:0] opc[2] = '{3'd0, 3'd4};
    int span[2] = '{20, 40};
    int want[2] = '{10, 4};
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      opcode = opc[k]; op1 = 8'd6; op2 = 8'd7; in_valid = 1'b1; out_ready = 1'b1;
      n = 0;
      for (int i = 0; i < span[k]; i++) begin
        if (in_ready) n++;
        @(negedge clk);
      end
      in_valid = 1'b0;
      t = 0;
      while (!in_ready && t < 30) begin
        @(negedge clk);
        t++;
      end
      out_ready = 1'b0;
      vectors++;
      if (n != want[k] || !in_ready) begin
        miscompares++;
        $display("FAIL back_to_back[%0d] got accepts=%0d idle=%b, want accepts=%0d idle=1",
                 k, n, in_ready, want[k]);
      end
    end
  endtask

  initial begin
    test_reset;
    test_add_sub;
    test_shifts;
    test_mul;
    test_backpressure;
    test_illegal;
    test_reset_mid_mul;
    test_random;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised sequential ALU for the calculator datapath, successor to the 4-bit combinational add/sub/shift unit. Accepts one signed operand pair per transaction over a valid/ready handshake and computes add, subtract, logical-left shift, arithmetic-right shift or an iterative signed multiply. Results are sign-extended to double width, registered, and held until the display/control stage accepts them.

## Interface
- `W`, default 8: operand width in bits (≥2). Result width `RW` = 2·W.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: operand pair and opcode valid.
- `in_ready` out 1: block can accept a transaction.
- `op1` in W: signed operand A.
- `op2` in W: signed operand B; shift amount for shifts.
- `opcode` in 3: 000 add, 001 sub, 010 shl, 011 sar, 100 mul, others illegal.
- `out_valid` out 1: result registers valid.
- `out_ready` in 1: consumer accepts the result.
- `result` out RW: signed result.
- `ovf` out 1: shl lost significant bits.
- `err` out 1: illegal opcode or negative shift amount.

## Operation
- FSM states: IDLE, MUL, DONE.
- IDLE: `in_ready`=1. On `in_valid`: latch operands/opcode, sign-extend both to RW.
  - add/sub/shl/sar/illegal: compute in the same cycle, register into `result`/flags, go to DONE.
  - mul: load magnitudes |op1|, |op2|, clear accumulator, load counter = W, record sign = op1[W-1]^op2[W-1]; go to MUL.
- MUL: each cycle, if multiplier LSB=1, add shifted multiplicand to accumulator; shift multiplicand left 1, multiplier right 1; decrement counter. When counter reaches 1 (last step), write accumulator (negated if sign) to `result`, go to DONE. Exactly W cycles in MUL. -2^(W-1) × -2^(W-1) = 2^(2W-2) must be exact (magnitudes held W+1 bits wide as needed).
- DONE: `out_valid`=1; `result`, `ovf`, `err` stable. On `out_ready`: go to IDLE. No new input accepted in DONE.
- Arithmetic rules (all in RW bits, two's complement):
  - add/sub: exact, never overflow; `ovf`=0.
  - shl: amount = op2 as signed. If negative: `result`=0, `err`=1. If amount ≥ RW: `result`=0, `ovf`=(op1≠0). Otherwise `result`=ext(op1)<<amt; `ovf`=1 iff (result>>>amt)≠ext(op1).
  - sar: negative amount → `result`=0, `err`=1. amount ≥ RW → all sign bits (0 or -1). Otherwise ext(op1)>>>amt. `ovf`=0.
  - mul: exact signed product; `ovf`=0.
  - illegal opcode: `result`=0, `err`=1, `ovf`=0.
- `err` and `ovf` are only meaningful while `out_valid`=1; cleared when a new transaction is accepted.

## Timing
- Reset (asserted any time, including mid-MUL or in DONE): state IDLE, `in_ready`=1 after deassert, `out_valid`=0, `result`=0, `ovf`=0, `err`=0; in-flight transaction discarded.
- Accept cycle = rising edge with IDLE & `in_valid`.
- Single-cycle ops: `out_valid` rises at edge after accept (latency 1).
- mul: `out_valid` rises W+1 edges after accept (W=8: 9).
- Back-to-back throughput: 1 transaction per 2 cycles (non-mul) when `out_ready` held high; per W+2 for mul.
- `out_ready` asserted while `out_valid`=0 has no effect. Inputs ignored outside IDLE; `op1`/`op2` may change after accept.
- `in_ready` is a pure function of state (no combinational path from `in_valid`/`out_ready`).

## Test plan
- W=8: add 127+127 -> 254 (0x00FE), sub -128-127 -> -255 (0xFF01); `out_valid` one cycle after accept, `ovf`=`err`=0.
- W=8 shifts: shl 0x40<<9 -> 0x8000, `ovf`=1; shl 3<<2 -> 12, `ovf`=0; sar -128>>>3 -> -16; sar -1>>>20 -> -1; shl 5 by -1 -> 0, `err`=1.
- W=8 mul: -128×-128 -> 16384, 127×-128 -> -16256, 0×-5 -> 0; each `out_valid` exactly 9 edges after accept, `in_ready`=0 throughout.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE -> `result`/flags stable, `in_valid` pulses ignored; release -> IDLE next edge, next transaction accepted.
- Opcode 111 -> `result`=0, `err`=1; following legal add clears `err`.
- Assert `rst_n` low mid-MUL (cycle 4) -> all outputs 0 immediately; after release a new add 2+3 -> 5 with normal latency.
